// File: rtl/cpu_regfile_pkg.sv
// Shared types and preset contents for the multi-port register file.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cpu_regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        int unsigned idx;
        logic [63:0] val;
    } preset_t;

    // Power-on contents; any register not listed here loads zero.
    localparam int PRESET_N = 3;
    localparam preset_t PRESET_TABLE [PRESET_N] = '{
        '{idx: 32'd1, val: 64'd7},
        '{idx: 32'd2, val: 64'd3},
        '{idx: 32'd3, val: 64'd49}
    };

    function automatic logic [63:0] preset_value(input int unsigned index);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < PRESET_N; i++) begin
            if (PRESET_TABLE[i].idx == index) v = PRESET_TABLE[i].val;
        end
        return v;
    endfunction

endpackage

// File: rtl/cpu_regfile_init_seq.sv
// Preset sequencer: after reset or init_req, emits one preset write per cycle for every register.
// Latency: sweep takes exactly NREG cycles; busy rises the cycle after the reset/request edge.
// Backpressure: none; the sweep cannot be stalled, only restarted by rst.
// Ports: clk, rst (sync, active-high), init_req (ignored while busy),
//        busy/init_we (sweep active), init_addr/init_data (current preset write).
module cpu_regfile_init_seq
    import cpu_regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init_req,
    output logic            busy,
    output logic            init_we,
    output logic [AW-1:0]   init_addr,
    output logic [XLEN-1:0] init_data
);

    state_t        state;
    logic [AW-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            busy  <= 1'b1;
            idx   <= '0;
        end else begin
            case (state)
                INIT: begin
                    idx <= idx + 1'b1;
                    if (idx == AW'(NREG - 1)) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (init_req) begin
                        state <= INIT;
                        busy  <= 1'b1;
                        idx   <= '0;
                    end
                end
                default: begin
                    state <= INIT;
                    busy  <= 1'b1;
                    idx   <= '0;
                end
            endcase
        end
    end

    assign init_we   = busy;
    assign init_addr = idx;
    // Register 0 is swept with zero when hardwired, whatever the table says.
    assign init_data = (ZERO_REG != 0 && idx == '0) ? '0 : XLEN'(preset_value(32'(idx)));

endmodule

// File: rtl/cpu_regfile_mp.sv
// Parametrised multi-port register file with optional r0-hardwire, write bypass and preset sweep.
// Latency: reads combinational (zero cycles); writes visible to storage after the clock edge.
// Backpressure: none on ports; while busy, writes and init_req are dropped and reads return 0.
// Ports: raddr/rdata (NRD packed read ports), we/waddr/wdata (NWR packed write ports),
//        init_req (restart preset sweep), busy (sweep running), wr_conflict (sticky same-address dual write).
module cpu_regfile_mp
    import cpu_regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                init_req,
    output logic                busy,
    output logic                wr_conflict
);

    logic [XLEN-1:0] regs [NREG];

    logic            init_we;
    logic [AW-1:0]   init_addr;
    logic [XLEN-1:0] init_data;
    logic [NWR-1:0]  wr_en;
    logic            collide;

    cpu_regfile_init_seq #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .init_req  (init_req),
        .busy      (busy),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    // A user write only happens in RUN and not in the cycle that requests a re-init.
    assign wr_en = we & {NWR{~busy & ~init_req}};

    // Higher-numbered ports are applied last so port 1 wins an address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (init_we) begin
                regs[init_addr] <= init_data;
            end else begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && !(ZERO_REG != 0 && waddr[j*AW +: AW] == '0)) begin
                        regs[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    if (NWR > 1) begin : g_collide
        assign collide = wr_en[0] && wr_en[1] && (waddr[0 +: AW] == waddr[AW +: AW])
                         && !(ZERO_REG != 0 && waddr[0 +: AW] == '0);
    end else begin : g_no_collide
        assign collide = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_conflict <= 1'b0;
        end else if (collide) begin
            wr_conflict <= 1'b1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] v;

        assign ra = raddr[k*AW +: AW];

        always_comb begin
            v = regs[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && waddr[j*AW +: AW] == ra) v = wdata[j*XLEN +: XLEN];
                end
            end
            // The hardwired zero overrides any bypass hit.
            if (busy || (ZERO_REG != 0 && ra == '0)) v = '0;
        end

        assign rdata[k*XLEN +: XLEN] = v;
    end

endmodule

// File: tb/tb_cpu_regfile_mp.sv
module tb_cpu_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        init_req;
    logic        busy;
    logic        wr_conflict;

    logic [31:0] rdata_nb;
    logic        busy_nb;
    logic        wr_conflict_nb;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    // Main instance: two write ports, bypass on.
    cpu_regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .raddr       (raddr),
        .rdata       (rdata),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .init_req    (init_req),
        .busy        (busy),
        .wr_conflict (wr_conflict)
    );

    // Second instance: one read, one write port, bypass off; shares port 0 stimulus.
    cpu_regfile_mp #(.XLEN(32), .NREG(32), .NRD(1), .NWR(1), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk         (clk),
        .rst         (rst),
        .raddr       (raddr[4:0]),
        .rdata       (rdata_nb),
        .we          (we[0]),
        .waddr       (waddr[4:0]),
        .wdata       (wdata[31:0]),
        .init_req    (init_req),
        .busy        (busy_nb),
        .wr_conflict (wr_conflict_nb)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Counts clock edges until busy drops, bounded.
    task automatic busy_len(output int cnt);
        cnt = 0;
        while (busy && cnt < 200) begin
            cyc();
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; raddr = '0; we = '0; waddr = '0; wdata = '0; init_req = 1'b0;
        cyc();
        cyc();
        chk("rst_busy", busy, 1);
        chk("rst_conflict", wr_conflict, 0);
        rst = 1'b0;

        // 1: sweep length and defaults
        raddr = {5'd2, 5'd1};
        #1 chk("busy_rdata0", rdata[31:0], 0);
        busy_len(n);
        chk("init_len", n, 32);
        chk("nb_busy_done", busy_nb, 0);
        #1;
        chk("def_r1", rdata[31:0], 7);
        chk("def_r2", rdata[63:32], 3);
        raddr = {5'd0, 5'd3};
        #1;
        chk("def_r3", rdata[31:0], 49);
        chk("def_r0", rdata[63:32], 0);
        chk("nb_def_r3", rdata_nb, 49);

        // 2: write with same-cycle read
        we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'hDEADBEEF}; raddr = {5'd0, 5'd5};
        #1;
        chk("byp_same", rdata[31:0], 32'hDEADBEEF);
        chk("nobyp_same", rdata_nb, 0);
        cyc();
        we = 2'b00;
        #1;
        chk("byp_next", rdata[31:0], 32'hDEADBEEF);
        chk("nobyp_next", rdata_nb, 32'hDEADBEEF);

        // 3: register 0, including a dual write to address 0
        we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'd0, 32'h1234}; raddr = {5'd0, 5'd0};
        #1 chk("r0_same", rdata[31:0], 0);
        cyc();
        we = 2'b11; wdata = {32'h5678, 32'h1234};
        #1 chk("r0_next", rdata[31:0], 0);
        cyc();
        we = 2'b00;
        #1;
        chk("r0_after", rdata[31:0], 0);
        chk("nb_r0_after", rdata_nb, 0);
        chk("r0_noconflict", wr_conflict, 0);

        // distinct addresses on both write ports
        we = 2'b11; waddr = {5'd11, 5'd10}; wdata = {32'hB, 32'hA};
        cyc();
        we = 2'b00; raddr = {5'd11, 5'd10};
        #1;
        chk("dual_r10", rdata[31:0], 32'hA);
        chk("dual_r11", rdata[63:32], 32'hB);
        chk("dual_noconflict", wr_conflict, 0);

        // 4: collision, port 1 wins
        we = 2'b11; waddr = {5'd9, 5'd9}; wdata = {32'h22, 32'h11}; raddr = {5'd0, 5'd9};
        #1;
        chk("col_byp", rdata[31:0], 32'h22);
        chk("col_pre", wr_conflict, 0);
        cyc();
        we = 2'b00;
        #1;
        chk("col_r9", rdata[31:0], 32'h22);
        chk("col_flag", wr_conflict, 1);
        cyc(); cyc(); cyc();
        chk("col_sticky", wr_conflict, 1);

        // 5: re-init discards the coincident write
        we = 2'b01; waddr = {5'd0, 5'd1}; wdata = {32'd0, 32'hFF};
        cyc();
        we = 2'b00; raddr = {5'd0, 5'd1};
        #1 chk("ff_r1", rdata[31:0], 32'hFF);
        init_req = 1'b1; we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'd0, 32'hAA};
        cyc();
        init_req = 1'b0;
        we = 2'b01; waddr = {5'd0, 5'd6}; wdata = {32'd0, 32'h66};
        chk("reinit_busy", busy, 1);
        busy_len(n);
        we = 2'b00;
        chk("reinit_len", n, 32);
        raddr = {5'd4, 5'd1};
        #1;
        chk("reinit_r1", rdata[31:0], 7);
        chk("reinit_r4", rdata[63:32], 0);
        chk("nb_reinit_r1", rdata_nb, 7);
        raddr = {5'd0, 5'd6};
        #1 chk("reinit_r6", rdata[31:0], 0);
        chk("reinit_sticky", wr_conflict, 1);

        // 6: reset ten cycles into the sweep
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'd0, 32'h77};
        for (int i = 0; i < 10; i++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_clears_conflict", wr_conflict, 0);
        waddr = {5'd0, 5'd8}; wdata = {32'd0, 32'h88};
        busy_len(n);
        we = 2'b00;
        chk("midrst_len", n, 32);
        raddr = {5'd8, 5'd7};
        #1;
        chk("midrst_r7", rdata[31:0], 0);
        chk("midrst_r8", rdata[63:32], 0);
        raddr = {5'd3, 5'd2};
        #1;
        chk("midrst_r2", rdata[31:0], 3);
        chk("midrst_r3", rdata[63:32], 49);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
